// File: rtl/axi_wr_slave.sv
// AXI-style single-burst write responder for the DDR2 front end.
// Handshake rule used on every channel: a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge; valid never waits
// on ready. All ready/valid outputs are decoded from state and FIFO status only.
module axi_wr_slave #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [8:0]            cmd_len,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic                  wr_ack,
  output logic                  err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_ACK,
    S_RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [8:0]            beats_left;
  logic                  ack_seen;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  fifo_full;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  pop;
  logic                  last_beat;

  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign dout_valid = (count != '0);
  assign dout       = mem[rd_ptr];
  assign aw_hs      = axi_awvalid && axi_awready;
  assign w_hs       = axi_wvalid && axi_wready;
  assign pop        = dout_valid && dout_ready;
  assign last_beat  = (beats_left == 9'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (axi_awvalid)              state_nxt = S_CMD;
      S_CMD:  if (cmd_ready)                state_nxt = S_DATA;
      S_DATA: if (w_hs && last_beat)        state_nxt = S_ACK;
      S_ACK:  if (ack_seen || wr_ack)       state_nxt = S_RESP;
      S_RESP: if (axi_bready)               state_nxt = S_IDLE;
      default:                              state_nxt = S_IDLE;
    endcase
  end

  // Channel ready/valid outputs decoded from state and FIFO level
  always_comb begin
    axi_awready = (state == S_IDLE);
    cmd_valid   = (state == S_CMD);
    axi_wready  = (state == S_DATA) && !fifo_full;
    axi_bvalid  = (state == S_RESP);
  end

  // Command capture and beat countdown; command fields hold until the next AW
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_addr   <= '0;
      cmd_len    <= '0;
      beats_left <= '0;
    end else if (aw_hs) begin
      cmd_addr   <= axi_awaddr;
      cmd_len    <= (axi_awlen == 8'd0) ? 9'd256 : {1'b0, axi_awlen};
      beats_left <= (axi_awlen == 8'd0) ? 9'd256 : {1'b0, axi_awlen};
    end else if (w_hs) begin
      beats_left <= beats_left - 9'd1;
    end
  end

  // Remember a commit acknowledge that arrives before the last beat
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_seen <= 1'b0;
    end else if (aw_hs) begin
      ack_seen <= 1'b0;
    end else if (wr_ack && (state == S_CMD || state == S_DATA || state == S_ACK)) begin
      ack_seen <= 1'b1;
    end
  end

  // Sticky WLAST error: the marker disagrees with the AWLEN-derived count
  always_ff @(posedge clk) begin
    if (!rstn)                                err <= 1'b0;
    else if (w_hs && (axi_wlast != last_beat)) err <= 1'b1;
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_hs) mem[wr_ptr] <= axi_wdata;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (w_hs) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({w_hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Bench for axi_wr_slave: directed burst scenarios with randomized data,
// handshake gaps and sink readiness, checked against a queue-based model.
module tb_axi_wr_slave;

  localparam int AW    = 27;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [DW-1:0] axi_wdata;
  logic          axi_wlast;
  logic          axi_bvalid;
  logic          axi_bready;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [8:0]    cmd_len;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          wr_ack;
  logic          err;

  axi_wr_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .wr_ack(wr_ack), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  bit            exp_err = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [8:0]    last_len = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // pattern: 0 random, 1 (i+1)*0x1111, 2 beat index.
  // hold>0: sink stalls until the FIFO has sat full for 3 cycles.
  // bad_idx>=0: wlast is driven on that beat only.
  // abort_after>=0: reset is applied once that many beats were accepted.
  task automatic burst(input logic [AW-1:0] addr, input logic [7:0] len8, input int pattern,
                       input int ready_pct, input int hold, input int bad_idx,
                       input bit early_ack, input int abort_after);
    int            n;
    logic [DW-1:0] data[$];
    int            bi, pops, lcyc, acyc, pcyc, resp, stall, guard, d;
    bit            ack_sent, fresh;
    logic          wr_obs, dv_obs, bv_obs;
    logic [DW-1:0] dout_obs;
    n = (len8 == 8'd0) ? 256 : int'(len8);
    for (int i = 0; i < n; i++) begin
      if (pattern == 1)      data.push_back(16'((i + 1) * 16'h1111));
      else if (pattern == 2) data.push_back(16'(i));
      else                   data.push_back(16'($urandom));
    end
    bi = 0; pops = 0; lcyc = -1; acyc = -1; pcyc = -1; resp = -1; stall = 0; guard = 0;
    ack_sent = 1'b0; fresh = 1'b0;

    // Address phase; a W beat is already offered and must wait for DATA
    axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = len8;
    axi_wvalid = 1'b1; axi_wdata = data[0];
    axi_wlast = (bad_idx >= 0) ? (bad_idx == 0) : (n == 1);
    check("awready_idle", axi_awready, 1);
    check("cmd_valid_idle", cmd_valid, 0);
    tick();
    axi_awvalid = 1'b0;
    check("cmd_valid", cmd_valid, 1);
    check("cmd_addr", cmd_addr, addr);
    check("cmd_len", cmd_len, n);
    check("wready_in_cmd", axi_wready, 0);
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      tick();
      check("cmd_valid_hold", cmd_valid, 1);
      check("wready_in_cmd", axi_wready, 0);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // Data / ack / response phase, one iteration per cycle
    while (guard < 5000) begin
      wr_obs = axi_wready; dv_obs = dout_valid; dout_obs = dout; bv_obs = axi_bvalid;
      if (model_cnt == DEPTH) stall++;
      check("wready", wr_obs, (bi < n) && (model_cnt < DEPTH));
      check("dout_valid", dv_obs, model_cnt != 0);
      check("bvalid", bv_obs, (resp >= 0) && (cyc >= resp));
      check("cmd_valid_busy", cmd_valid, 0);
      check("awready_busy", axi_awready, 0);
      check("err", err, exp_err);
      if (resp >= 0 && cyc >= resp && exp_q.size() == 0) break;
      if (abort_after >= 0 && bi == abort_after) break;

      if (bi < n) begin
        if (!axi_wvalid || fresh) axi_wvalid = ($urandom_range(0, 2) != 0);
        fresh = 1'b0;
        axi_wdata = data[bi];
        axi_wlast = (bad_idx >= 0) ? (bi == bad_idx) : (bi == n - 1);
      end else begin
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
      end

      if (hold > 0 && stall < 3) dout_ready = 1'b0;
      else                       dout_ready = ($urandom_range(0, 99) < ready_pct);

      wr_ack = 1'b0;
      if (!ack_sent && early_ack && bi >= 1) begin
        wr_ack = 1'b1; acyc = cyc; ack_sent = 1'b1;
      end else if (!ack_sent && !early_ack && pcyc >= 0 && cyc == pcyc + 2) begin
        wr_ack = 1'b1; acyc = cyc; ack_sent = 1'b1;
      end

      if (dv_obs && dout_ready && exp_q.size() > 0) begin
        check("dout", dout_obs, exp_q[0]);
        void'(exp_q.pop_front());
        model_cnt--;
        pops++;
        if (pops == n) pcyc = cyc;
      end
      if (axi_wvalid && wr_obs) begin
        exp_q.push_back(data[bi]);
        model_cnt++;
        if (axi_wlast != (bi == n - 1)) exp_err = 1'b1;
        if (bi == n - 1) lcyc = cyc;
        bi++;
        fresh = 1'b1;
      end
      if (resp < 0 && lcyc >= 0 && acyc >= 0)
        resp = ((lcyc + 1 > acyc) ? lcyc + 1 : acyc) + 1;
      tick();
      guard++;
    end
    wr_ack = 1'b0;
    dout_ready = 1'b0;
    if (guard >= 5000) check("burst_timeout", 0, 1);

    if (abort_after >= 0) begin
      axi_wvalid = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      exp_q.delete(); model_cnt = 0; exp_err = 1'b0;
      check("rst_awready", axi_awready, 1);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_bvalid", axi_bvalid, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_wready", axi_wready, 0);
      check("rst_cmd_addr", cmd_addr, 0);
      check("rst_err", err, 0);
      last_addr = '0; last_len = '0;
      return;
    end

    check("pops_total", pops, n);
    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      tick();
      check("bvalid_wait", axi_bvalid, 1);
    end
    last_addr = addr;
    last_len  = 9'(n);
  endtask

  // Response handshake, optionally with the next AW offered in the same cycle
  task automatic b_phase(input bit next_aw, input logic [AW-1:0] addr, input logic [7:0] len8);
    axi_bready = 1'b1;
    if (next_aw) begin
      axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = len8;
    end
    check("bvalid_at_b", axi_bvalid, 1);
    check("awready_in_resp", axi_awready, 0);
    tick();
    axi_bready = 1'b0;
    check("bvalid_after_b", axi_bvalid, 0);
    check("awready_after_b", axi_awready, 1);
    check("cmd_valid_after_b", cmd_valid, 0);
    check("cmd_addr_kept", cmd_addr, last_addr);
    check("cmd_len_kept", cmd_len, last_len);
  endtask

  logic [AW-1:0] a_next;
  logic [7:0]    l_next;

  initial begin
    rstn = 1'b0;
    axi_awvalid = 1'b0; axi_awaddr = '0; axi_awlen = '0;
    axi_wvalid = 1'b0; axi_wdata = '0; axi_wlast = 1'b0;
    axi_bready = 1'b0; cmd_ready = 1'b0; dout_ready = 1'b0; wr_ack = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    check("reset_awready", axi_awready, 1);
    check("reset_wready", axi_wready, 0);
    check("reset_bvalid", axi_bvalid, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_cmd_addr", cmd_addr, 0);
    check("reset_cmd_len", cmd_len, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_err", err, 0);
    rstn = 1'b1;
    tick();

    // Single 8-beat burst with fixed data, ack two cycles after last pop
    burst(27'h100, 8'd8, 1, 100, 0, -1, 1'b0, -1);
    b_phase(1'b0, '0, '0);

    // 32-beat burst against a stalled sink: FIFO fills to 16
    burst(27'h2000, 8'd32, 0, 100, 16, -1, 1'b0, -1);
    b_phase(1'b0, '0, '0);

    // A stray ack in IDLE must not shortcut the next burst
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;

    // Early ack during DATA plus wlast on beat 3 of 4
    burst(27'h3000, 8'd4, 0, 70, 0, 2, 1'b1, -1);
    b_phase(1'b0, '0, '0);

    // Clean burst keeps err, then back-to-back AW during B
    a_next = AW'($urandom);
    l_next = 8'($urandom_range(1, 12));
    burst(AW'($urandom), 8'($urandom_range(1, 20)), 0, 60, 0, -1, 1'b0, -1);
    check("err_sticky", err, 1);
    b_phase(1'b1, a_next, l_next);
    burst(a_next, l_next, 0, 80, 0, -1, 1'b1, -1);
    b_phase(1'b0, '0, '0);

    // awlen=0 encodes 256 beats
    burst(27'h4000, 8'd0, 2, 80, 0, -1, 1'b0, -1);
    b_phase(1'b0, '0, '0);

    // Randomized bursts
    for (int r = 0; r < 4; r++) begin
      burst(AW'($urandom), 8'($urandom_range(1, 40)), 0, $urandom_range(30, 100), 0, -1,
            1'($urandom_range(0, 1)), -1);
      b_phase(1'b0, '0, '0);
    end

    // Reset after 3 of 8 beats, then a normal 4-beat burst
    burst(27'h5000, 8'd8, 0, 0, 0, -1, 1'b0, 3);
    burst(27'h6000, 8'd4, 0, 90, 0, -1, 1'b0, -1);
    b_phase(1'b0, '0, '0);
    check("err_after_reset_burst", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
